// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared types and helpers for the pipelined add/subtract unit.
//               op_e selects the operation; calc_nstage() derives the number
//               of pipeline stages from the operand and slice widths.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of SEG-bit slices in a WIDTH-bit operand. An illegal SEG is
    // mapped to 1 so the division stays defined; the top flags it separately.
    function automatic int calc_nstage(input int width, input int seg);
        return (seg < 1) ? 1 : (width / seg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_segment.sv
`default_nettype none
// ============================================================================
// Module      : adder_segment
// Description : Combinational SEG-bit ripple-carry slice. One instance per
//               pipeline stage of pipelined_addsub.
// Ports       : a, b   in  SEG  slice operands (b already inverted for SUB)
//               ci     in  1    carry into the slice LSB
//               s      out SEG  slice sum
//               co     out 1    carry out of the slice MSB
//               c_msb  out 1    carry into the slice MSB (signed overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module adder_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] carry_w;

    always_comb begin
        carry_w    = '0;
        s          = '0;
        carry_w[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_w[i];
            carry_w[i+1] = (a[i] & b[i]) | (carry_w[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = carry_w[SEG];
    assign c_msb = carry_w[SEG-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_addsub
// Description : Pipelined add/subtract unit. Operands are resolved SEG bits
//               per stage with the inter-slice carry registered, so the
//               critical path is one SEG-bit ripple regardless of WIDTH.
//               Valid/ready on both sides; a back-pressured output freezes
//               the whole pipeline.
// Ports       : clk, rst_n            clock, synchronous active-low reset
//               in_valid/in_ready     operand handshake
//               op, x, y, cin         operation and operands
//               out_valid/out_ready   result handshake
//               sum, cout, ovf        result, MSB carry, signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTAGE = calc_nstage(WIDTH, SEG);

    if ((SEG < 1) || ((WIDTH % ((SEG < 1) ? 1 : SEG)) != 0)) begin : g_param_check
        $error("pipelined_addsub: WIDTH (%0d) must be a positive multiple of SEG (%0d)",
               WIDTH, SEG);
    end

    logic             advance_w;
    logic             sub_w;
    logic [WIDTH-1:0] y_eff_w;
    logic             ci0_w;
    logic             ovf_q;

    // Whole pipeline advances unless the final stage holds an unaccepted beat.
    assign in_ready  = !out_valid || out_ready;
    assign advance_w = in_ready;

    // Subtraction is x + ~y + 1: invert y up front and force the LSB carry.
    assign sub_w   = (op == OP_SUB);
    assign y_eff_w = sub_w ? ~y : y;
    assign ci0_w   = sub_w | cin;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int RW = (k + 1) * SEG;   // result bits resolved after this stage
        localparam int OW = WIDTH - RW;      // operand bits still to be resolved

        logic [OW+SEG-1:0] a_src_w;          // operand bits from this slice upward
        logic [OW+SEG-1:0] b_src_w;
        logic              ci_w;
        logic              v_in_w;
        logic [SEG-1:0]    s_w;
        logic              co_w;
        logic              c_msb_w;
        logic [RW-1:0]     r_d;

        logic              v_q;
        logic              c_q;
        logic [RW-1:0]     r_q;

        if (k == 0) begin : g_head
            assign a_src_w = x;
            assign b_src_w = y_eff_w;
            assign ci_w    = ci0_w;
            assign v_in_w  = in_valid;
            assign r_d     = s_w;
        end else begin : g_body
            assign a_src_w = g_stage[k-1].g_ops.a_q;
            assign b_src_w = g_stage[k-1].g_ops.b_q;
            assign ci_w    = g_stage[k-1].c_q;
            assign v_in_w  = g_stage[k-1].v_q;
            // Lower slices ride along so the whole word emerges together.
            assign r_d     = {s_w, g_stage[k-1].r_q};
        end

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a     (a_src_w[SEG-1:0]),
            .b     (b_src_w[SEG-1:0]),
            .ci    (ci_w),
            .s     (s_w),
            .co    (co_w),
            .c_msb (c_msb_w)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (advance_w) begin
                v_q <= v_in_w;
                c_q <= co_w;
                r_q <= r_d;
            end
        end

        if (OW > 0) begin : g_ops
            // Upper operand slices skewed forward with the beat.
            logic [OW-1:0] a_q;
            logic [OW-1:0] b_q;
            // Carry into the slice MSB only matters for the top slice.
            logic          unused_c_msb_w;

            assign unused_c_msb_w = c_msb_w;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance_w) begin
                    a_q <= a_src_w[OW+SEG-1:SEG];
                    b_q <= b_src_w[OW+SEG-1:SEG];
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance_w) begin
                    ovf_q <= c_msb_w ^ co_w;
                end
            end
        end
    end

    assign out_valid = g_stage[NSTAGE-1].v_q;
    assign sum       = g_stage[NSTAGE-1].r_q;
    assign cout      = g_stage[NSTAGE-1].c_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_addsub
// Description : Self-checking bench for pipelined_addsub. Three instances:
//               32/8 (main), 16/16 (single stage) and 24/4 (six stages).
//               Results are compared against an arithmetic reference model
//               through per-instance FIFO scoreboards plus directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;
    import adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DUT A: 32/8 ----------------
    logic        a_in_valid, a_in_ready, a_cin, a_out_valid, a_out_ready, a_cout, a_ovf;
    op_e         a_op;
    logic [31:0] a_x, a_y, a_sum;

    pipelined_addsub #(.WIDTH(32), .SEG(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .x(a_x), .y(a_y), .cin(a_cin), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .sum(a_sum), .cout(a_cout), .ovf(a_ovf)
    );

    // ---------------- DUT B: 16/16 ----------------
    logic        b_in_valid, b_in_ready, b_cin, b_out_valid, b_out_ready, b_cout, b_ovf;
    op_e         b_op;
    logic [15:0] b_x, b_y, b_sum;

    pipelined_addsub #(.WIDTH(16), .SEG(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .x(b_x), .y(b_y), .cin(b_cin), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
    );

    // ---------------- DUT C: 24/4 ----------------
    logic        c_in_valid, c_in_ready, c_cin, c_out_valid, c_out_ready, c_cout, c_ovf;
    op_e         c_op;
    logic [23:0] c_x, c_y, c_sum;

    pipelined_addsub #(.WIDTH(24), .SEG(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .op(c_op), .x(c_x), .y(c_y), .cin(c_cin), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .sum(c_sum), .cout(c_cout), .ovf(c_ovf)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    function automatic exp_t ref_calc(input int w, input bit sub,
                                      input longint unsigned a, input longint unsigned b,
                                      input bit ci);
        exp_t              r;
        longint unsigned   mask, am, bb, full;
        mask   = (64'd1 << w) - 64'd1;
        am     = a & mask;
        bb     = sub ? (~b & mask) : (b & mask);
        full   = am + bb + (sub ? 64'd1 : 64'(ci));
        r.sum  = 32'(full & mask);
        r.cout = full[w];
        // Same-sign operands producing a result of the other sign.
        r.ovf  = (am[w-1] == bb[w-1]) && (full[w-1] != am[w-1]);
        r.acc  = 0;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboards ----------------
    exp_t        qa[$], qb[$], qc[$];
    exp_t        ea, eb, ec;
    bit          a_stall_prev = 1'b0;
    logic [33:0] a_out_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            a_stall_prev = 1'b0;
        end else begin
            if (a_stall_prev) begin
                check("a_stall_valid_hold", 64'(a_out_valid), 64'd1);
                check("a_stall_data_hold", 64'({a_ovf, a_cout, a_sum}), 64'(a_out_prev));
            end
            if (a_in_valid && a_in_ready)
                qa.push_back(ref_calc(32, a_op == OP_SUB, 64'(a_x), 64'(a_y), a_cin));
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_spurious_beat: got sum 0x%0h expected no beat", a_sum);
                end else begin
                    ea = qa.pop_front();
                    check("a_sum", 64'(a_sum), 64'(ea.sum));
                    check("a_cout_ovf", 64'({a_cout, a_ovf}), 64'({ea.cout, ea.ovf}));
                end
            end
            a_stall_prev = a_out_valid && !a_out_ready;
            a_out_prev   = {a_ovf, a_cout, a_sum};
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (b_in_valid && b_in_ready) begin
                eb = ref_calc(16, b_op == OP_SUB, 64'(b_x), 64'(b_y), b_cin);
                eb.acc = cyc;
                qb.push_back(eb);
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_spurious_beat: got sum 0x%0h expected no beat", b_sum);
                end else begin
                    eb = qb.pop_front();
                    check("b_sum", 64'(b_sum), 64'(eb.sum[15:0]));
                    check("b_cout_ovf", 64'({b_cout, b_ovf}), 64'({eb.cout, eb.ovf}));
                    check("b_latency", 64'(cyc - eb.acc), 64'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qc.delete();
        end else begin
            if (c_in_valid && c_in_ready) begin
                ec = ref_calc(24, c_op == OP_SUB, 64'(c_x), 64'(c_y), c_cin);
                ec.acc = cyc;
                qc.push_back(ec);
            end
            if (c_out_valid && c_out_ready) begin
                if (qc.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL c_spurious_beat: got sum 0x%0h expected no beat", c_sum);
                end else begin
                    ec = qc.pop_front();
                    check("c_sum", 64'(c_sum), 64'(ec.sum[23:0]));
                    check("c_cout_ovf", 64'({c_cout, c_ovf}), 64'({ec.cout, ec.ovf}));
                    check("c_latency", 64'(cyc - ec.acc), 64'd6);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a beat on DUT A and hold it until accepted; returns 1ns after
    // the accepting edge.
    task automatic send_a(input bit sub, input logic [31:0] xv, input logic [31:0] yv,
                          input bit ci);
        int guard;
        bit done;
        guard      = 0;
        done       = 1'b0;
        a_op       = sub ? OP_SUB : OP_ADD;
        a_x        = xv;
        a_y        = yv;
        a_cin      = ci;
        a_in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = a_in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                guard++;
                if (guard > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL send_a_timeout: got in_ready 0 for %0d cycles expected 1", guard);
                    done = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        bit          sub;
        logic [31:0] xv;
        logic [31:0] yv;
        bit          ci;
        logic [31:0] esum;
        bit          ecout;
        bit          eovf;
    } vec_t;

    vec_t        vecs[11];
    logic [15:0] cb[4];
    logic [23:0] cc[4];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b1, 1'b0};
        cb[0] = 16'h0000; cb[1] = 16'h0001; cb[2] = 16'hFFFF; cb[3] = 16'h8000;
        cc[0] = 24'h0;    cc[1] = 24'h1;    cc[2] = 24'hFFFFFF; cc[3] = 24'h800000;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_op = OP_ADD; a_x = '0; a_y = '0; a_cin = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_op = OP_ADD; b_x = '0; b_y = '0; b_cin = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_op = OP_ADD; c_x = '0; c_y = '0; c_cin = 1'b0; c_out_ready = 1'b1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_sum", 64'(a_sum), 64'd0);
        check("rst_a_cout_ovf", 64'({a_cout, a_ovf}), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_c_out_valid_sum", 64'({c_out_valid, c_sum}), 64'd0);
        @(posedge clk); #1;

        // ---- latency of a single beat: out_valid exactly 4 edges after accept ----
        send_a(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        a_in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("lat4_out_valid", 64'(a_out_valid), 64'(i == 4));
        end
        check("lat4_sum", 64'(a_sum), 64'd0);
        check("lat4_cout", 64'(a_cout), 64'd1);
        check("lat4_ovf", 64'(a_ovf), 64'd0);
        @(posedge clk); #1;

        // ---- table of directed vectors ----
        for (int v = 0; v < 11; v++) begin
            int g;
            send_a(vecs[v].sub, vecs[v].xv, vecs[v].yv, vecs[v].ci);
            a_in_valid = 1'b0;
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!a_out_valid && g < 10);
            check("vec_out_valid", 64'(a_out_valid), 64'd1);
            check("vec_sum", 64'(a_sum), 64'(vecs[v].esum));
            check("vec_cout", 64'(a_cout), 64'(vecs[v].ecout));
            check("vec_ovf", 64'(a_ovf), 64'(vecs[v].eovf));
            @(posedge clk); #1;
        end

        // ---- 10 back-to-back random beats, outputs on 10 consecutive cycles ----
        for (int s = 0; s < 16; s++) begin
            if (s < 10) begin
                a_in_valid = 1'b1;
                a_op       = ($urandom_range(0, 1) != 0) ? OP_SUB : OP_ADD;
                a_x        = $urandom;
                a_y        = $urandom;
                a_cin      = 1'($urandom_range(0, 1));
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            check("b2b_out_valid", 64'(a_out_valid), 64'(s >= 4 && s <= 13));
            @(posedge clk); #1;
        end

        // ---- stall: 5 beats streamed into a blocked consumer ----
        a_out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_a(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
                a_in_valid = 1'b0;
            end
            begin
                int seen;
                int guard;
                seen  = 0;
                guard = 0;
                while (seen < 6 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                    check("stall_in_ready", 64'(a_in_ready), 64'(!a_out_valid));
                    if (a_out_valid) seen++;
                end
                if (seen < 6) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stall_wait: got %0d stalled cycles expected 6", seen);
                end
                @(posedge clk); #1;
                a_out_ready = 1'b1;
            end
        join
        repeat (12) @(posedge clk);
        #1;
        check("stall_drain_empty", 64'(qa.size()), 64'd0);

        // ---- reset with 3 beats in flight ----
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_a(1'b0, $urandom, $urandom, 1'b1);
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(a_out_valid), 64'd0);
        check("midrst_sum", 64'(a_sum), 64'd0);
        check("midrst_cout_ovf", 64'({a_cout, a_ovf}), 64'd0);
        check("midrst_in_ready", 64'(a_in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(a_out_valid), 64'd0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;

        // ---- random soak with random back-pressure ----
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_op        = ($urandom_range(0, 1) != 0) ? OP_SUB : OP_ADD;
            a_x         = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            a_y         = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            a_cin       = 1'($urandom_range(0, 1));
            a_out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("soak_drain_empty", 64'(qa.size()), 64'd0);

        // ---- corner operands on the 16/16 and 24/4 instances ----
        for (int xi = 0; xi < 4; xi++)
            for (int yi = 0; yi < 4; yi++)
                for (int o = 0; o < 2; o++)
                    for (int ci = 0; ci < 2; ci++) begin
                        b_in_valid = 1'b1;
                        b_op = (o != 0) ? OP_SUB : OP_ADD;
                        b_x = cb[xi]; b_y = cb[yi]; b_cin = 1'(ci);
                        c_in_valid = 1'b1;
                        c_op = (o != 0) ? OP_SUB : OP_ADD;
                        c_x = cc[xi]; c_y = cc[yi]; c_cin = 1'(ci);
                        @(posedge clk); #1;
                    end
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("b_drain_empty", 64'(qb.size()), 64'd0);
        check("c_drain_empty", 64'(qc.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
